// File: rtl/sample_fifo_pkg.sv
// Shared sizing helpers and pointer arithmetic for the sample FIFO.
package sample_fifo_pkg;

   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Non-power-of-two depths need an explicit wrap, not a free-running rollover.
   function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/sample_fifo_mem.sv
// DEPTH x WIDTH sample storage: synchronous write port, asynchronous read port.
module sample_fifo_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 3,
   parameter int PW    = 2
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/sample_fifo.sv
// Circular sample FIFO with empty bypass, protected overflow/underflow and sync flush.
module sample_fifo
   import sample_fifo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 3,
   parameter int AF_THRESH = DEPTH - 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [WIDTH-1:0]                  in,
   input  logic                              w_enable,
   input  logic                              r_enable,
   input  logic                              flush,
   output logic [WIDTH-1:0]                  out,
   output logic                              out_valid,
   output logic [cnt_w(DEPTH)-1:0]           count,
   output logic                              empty,
   output logic                              full,
   output logic                              almost_full,
   output logic                              overflow,
   output logic                              underflow
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] out_q, out_d, rd_data;
   logic             out_valid_q, out_valid_d;
   logic             empty_q, full_q, af_q;
   logic             ovf_q, ovf_d, udf_q, udf_d;
   logic             wr_acc, rd_acc, bypass, mem_we;

   assign wr_acc = w_enable && (!full_q || r_enable);
   assign rd_acc = r_enable && (!empty_q || w_enable);
   assign bypass = empty_q && r_enable && w_enable;

   sample_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wr_ptr_q),
      .wdata (in),
      .raddr (rd_ptr_q),
      .rdata (rd_data)
   );

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      ovf_d       = ovf_q;
      udf_d       = udf_q;
      mem_we      = 1'b0;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr_d = PW'(wrap_inc(32'(wr_ptr_q), DEPTH));
            mem_we   = !bypass;
         end else if (w_enable) begin
            ovf_d = 1'b1;
         end
         // When full, the read sees the old slot contents before the write edge lands.
         if (rd_acc) begin
            rd_ptr_d    = PW'(wrap_inc(32'(rd_ptr_q), DEPTH));
            out_d       = bypass ? in : rd_data;
            out_valid_d = 1'b1;
         end else if (r_enable) begin
            udf_d = 1'b1;
         end
         if (wr_acc && !rd_acc) count_d = count_q + 1'b1;
         else if (!wr_acc && rd_acc) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
         empty_q     <= 1'b1;
         full_q      <= 1'b0;
         af_q        <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         ovf_q       <= ovf_d;
         udf_q       <= udf_d;
         empty_q     <= (count_d == '0);
         full_q      <= (count_d == CW'(DEPTH));
         af_q        <= (count_d >= CW'(AF_THRESH));
      end
   end

   assign out         = out_q;
   assign out_valid   = out_valid_q;
   assign count       = count_q;
   assign empty       = empty_q;
   assign full        = full_q;
   assign almost_full = af_q;
   assign overflow    = ovf_q;
   assign underflow   = udf_q;

endmodule

// File: tb/tb_sample_fifo.sv
// Directed table plus corner sequences and a randomized queue-model run for sample_fifo.
module tb_sample_fifo;

   typedef struct {
      logic rst, fl, we, re;
      int   din;
      int   out;
      logic ov;
      int   cnt;
      logic emp, ful, af, ovf, udf;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   // DEPTH=5 instance
   logic       d5_rst = 1'b0, d5_we = 1'b0, d5_re = 1'b0, d5_fl = 1'b0;
   logic [7:0] d5_in = '0, d5_out;
   logic [2:0] d5_cnt;
   logic       d5_ov, d5_emp, d5_ful, d5_af, d5_ovf, d5_udf;

   sample_fifo #(.WIDTH(8), .DEPTH(5), .AF_THRESH(4)) u_d5 (
      .clk (clk), .reset (d5_rst), .in (d5_in), .w_enable (d5_we), .r_enable (d5_re),
      .flush (d5_fl), .out (d5_out), .out_valid (d5_ov), .count (d5_cnt), .empty (d5_emp),
      .full (d5_ful), .almost_full (d5_af), .overflow (d5_ovf), .underflow (d5_udf)
   );

   // DEPTH=3 instance
   logic       d3_rst = 1'b0, d3_we = 1'b0, d3_re = 1'b0, d3_fl = 1'b0;
   logic [7:0] d3_in = '0, d3_out;
   logic [1:0] d3_cnt;
   logic       d3_ov, d3_emp, d3_ful, d3_af, d3_ovf, d3_udf;

   sample_fifo #(.WIDTH(8), .DEPTH(3), .AF_THRESH(2)) u_d3 (
      .clk (clk), .reset (d3_rst), .in (d3_in), .w_enable (d3_we), .r_enable (d3_re),
      .flush (d3_fl), .out (d3_out), .out_valid (d3_ov), .count (d3_cnt), .empty (d3_emp),
      .full (d3_ful), .almost_full (d3_af), .overflow (d3_ovf), .underflow (d3_udf)
   );

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic vec_t mk(input logic rst, fl, we, re, input int din, out, input logic ov,
                               input int cnt, input logic emp, ful, af, ovf, udf);
      vec_t v;
      v.rst = rst; v.fl = fl; v.we = we; v.re = re; v.din = din; v.out = out; v.ov = ov;
      v.cnt = cnt; v.emp = emp; v.ful = ful; v.af = af; v.ovf = ovf; v.udf = udf;
      return v;
   endfunction

   vec_t tbl [20];
   int   w5 [5];

   initial begin
      //           rst fl we re din   out ov cnt e  f  af ovf udf
      tbl[0]  = mk(1, 0, 0, 0, 0,    0,  0, 0, 1, 0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 0, 0,    0,  0, 0, 1, 0, 0, 0, 0);
      tbl[2]  = mk(0, 0, 1, 1, 42,   42, 1, 0, 1, 0, 0, 0, 0);
      tbl[3]  = mk(0, 0, 0, 0, 0,    42, 0, 0, 1, 0, 0, 0, 0);
      tbl[4]  = mk(0, 0, 1, 0, 1,    42, 0, 1, 0, 0, 0, 0, 0);
      tbl[5]  = mk(0, 0, 1, 0, 2,    42, 0, 2, 0, 0, 1, 0, 0);
      tbl[6]  = mk(0, 0, 1, 0, 3,    42, 0, 3, 0, 1, 1, 0, 0);
      tbl[7]  = mk(0, 0, 1, 0, 4,    42, 0, 3, 0, 1, 1, 1, 0);
      tbl[8]  = mk(0, 0, 1, 1, 5,    1,  1, 3, 0, 1, 1, 1, 0);
      tbl[9]  = mk(0, 0, 0, 1, 0,    2,  1, 2, 0, 0, 1, 1, 0);
      tbl[10] = mk(0, 0, 0, 1, 0,    3,  1, 1, 0, 0, 0, 1, 0);
      tbl[11] = mk(0, 0, 0, 1, 0,    5,  1, 0, 1, 0, 0, 1, 0);
      tbl[12] = mk(0, 0, 0, 1, 0,    5,  0, 0, 1, 0, 0, 1, 1);
      tbl[13] = mk(0, 1, 0, 0, 0,    5,  0, 0, 1, 0, 0, 0, 0);
      tbl[14] = mk(0, 0, 1, 0, 9,    5,  0, 1, 0, 0, 0, 0, 0);
      tbl[15] = mk(0, 0, 1, 0, 10,   5,  0, 2, 0, 0, 1, 0, 0);
      tbl[16] = mk(0, 1, 0, 1, 0,    5,  0, 0, 1, 0, 0, 0, 0);
      tbl[17] = mk(0, 1, 1, 1, -7,   5,  0, 0, 1, 0, 0, 0, 0);
      tbl[18] = mk(0, 0, 1, 0, 7,    5,  0, 1, 0, 0, 0, 0, 0);
      tbl[19] = mk(1, 0, 1, 1, 8,    0,  0, 0, 1, 0, 0, 0, 0);
      w5[0] = -3; w5[1] = 7; w5[2] = -128; w5[3] = 127; w5[4] = 0;

      // DEPTH=5: reset state, fill, drain in order
      @(negedge clk);
      d5_rst = 1'b1;
      @(negedge clk);
      d5_rst = 1'b0;
      check("d5_reset_empty", d5_emp, 1);
      check("d5_reset_count", d5_cnt, 0);
      check("d5_reset_out", d5_out, 0);
      check("d5_reset_valid", d5_ov, 0);
      check("d5_reset_flags", {d5_ovf, d5_udf}, 0);
      for (int i = 0; i < 5; i++) begin
         d5_we = 1'b1;
         d5_in = 8'(w5[i]);
         @(negedge clk);
         check("d5_fill_count", d5_cnt, i + 1);
         check("d5_fill_af", d5_af, (i + 1 >= 4) ? 1 : 0);
      end
      d5_we = 1'b0;
      check("d5_full", d5_ful, 1);
      d5_re = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("d5_drain_out", int'($signed(d5_out)), w5[i]);
         check("d5_drain_valid", d5_ov, 1);
      end
      d5_re = 1'b0;
      check("d5_drained_empty", d5_emp, 1);
      check("d5_drained_count", d5_cnt, 0);
      check("d5_drained_full", d5_ful, 0);
      @(negedge clk);
      check("d5_idle_valid", d5_ov, 0);
      check("d5_idle_hold", int'($signed(d5_out)), 0);

      // DEPTH=3 directed table: bypass, overflow, full r+w, underflow, flush, reset priority
      for (int i = 0; i < 20; i++) begin
         d3_rst = tbl[i].rst;
         d3_fl  = tbl[i].fl;
         d3_we  = tbl[i].we;
         d3_re  = tbl[i].re;
         d3_in  = 8'(tbl[i].din);
         @(negedge clk);
         check($sformatf("v%0d_out", i), int'($signed(d3_out)), tbl[i].out);
         check($sformatf("v%0d_valid", i), d3_ov, tbl[i].ov);
         check($sformatf("v%0d_count", i), d3_cnt, tbl[i].cnt);
         check($sformatf("v%0d_status", i), {d3_emp, d3_ful, d3_af},
               {tbl[i].emp, tbl[i].ful, tbl[i].af});
         check($sformatf("v%0d_flags", i), {d3_ovf, d3_udf}, {tbl[i].ovf, tbl[i].udf});
      end
      d3_rst = 1'b0;
      d3_fl  = 1'b0;

      // DEPTH=3 randomized interleave against a queue model, exercising pointer wrap
      begin
         int   q [$];
         int   last_out = 0;
         logic m_ovf = 1'b0, m_udf = 1'b0;
         for (int i = 0; i < 40; i++) begin
            logic w, r, exp_v;
            int   din;
            w   = 1'($urandom_range(1));
            r   = 1'($urandom_range(1));
            din = int'($urandom_range(255)) - 128;
            d3_we = w;
            d3_re = r;
            d3_in = 8'(din);
            exp_v = 1'b0;
            if (r && q.size() == 0 && w) begin
               last_out = din;
               exp_v    = 1'b1;
            end else begin
               if (r) begin
                  if (q.size() > 0) begin
                     last_out = q.pop_front();
                     exp_v    = 1'b1;
                  end else begin
                     m_udf = 1'b1;
                  end
               end
               if (w) begin
                  if (q.size() < 3) q.push_back(din);
                  else m_ovf = 1'b1;
               end
            end
            @(negedge clk);
            check($sformatf("r%0d_out", i), int'($signed(d3_out)), last_out);
            check($sformatf("r%0d_valid", i), d3_ov, exp_v);
            check($sformatf("r%0d_count", i), d3_cnt, q.size());
            check($sformatf("r%0d_af", i), d3_af, (q.size() >= 2) ? 1 : 0);
            check($sformatf("r%0d_flags", i), {d3_ovf, d3_udf}, {m_ovf, m_udf});
         end
         d3_we = 1'b0;
         d3_re = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
